// File: rtl/aq_axis_djpeg_pixout_if.sv
// AXI4-Stream video bus (24-bit RGB) used between the JPEG pixel output stage and its sink.
interface aq_axis_djpeg_pixout_if;
  logic [23:0] TDATA;
  logic        TUSER;
  logic        TLAST;
  logic        TVALID;
  logic        TREADY;

  modport master (output TDATA, output TUSER, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TUSER, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/aq_axis_djpeg_pixout.sv
// JPEG decoder pixel output stage: buffers raster RGB pixels and drives an AXI4-Stream video master.
// Optional macro AQ_DJPEG_PIXOUT_OVF_EN adds a sticky OVF_ERR flag for stray decoder pixels.
module aq_axis_djpeg_pixout #(
  parameter int FIFO_AW = 4
) (
  input  logic                          ACLK,
  input  logic                          RST,
  input  logic                          FRAME_START,
  input  logic [15:0]                   WIDTH,
  input  logic [15:0]                   HEIGHT,
  input  logic                          PIX_VALID,
  input  logic [23:0]                   PIX_DATA,
  output logic                          PIX_READY,
  aq_axis_djpeg_pixout_if.master        M_AXIS,
  output logic                          LOGIC_IDLE,
  output logic [15:0]                   PIXELX,
  output logic [15:0]                   PIXELY,
  output logic                          DBG_STATE
`ifdef AQ_DJPEG_PIXOUT_OVF_EN
  ,
  output logic                          OVF_ERR
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] L_DEPTH = DEPTH[FIFO_AW:0];

  // Handshakes: a transfer happens on a rising ACLK edge where valid and ready are both 1;
  // valid never waits on ready, and the source holds its payload until that edge.

  state_t              r_state, w_state_nxt;
  logic [23:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [31:0]         r_in_cnt, r_total;
  logic [15:0]         r_w, r_h, r_ox, r_oy;
  logic [15:0]         r_pixelx, r_pixely;

  logic w_full, w_empty, w_push, w_pop, w_in_done, w_start, w_last_x, w_last_beat;
  logic w_pix_ready;

  assign w_full      = (r_count == L_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_in_done   = (r_in_cnt == r_total);
  assign w_start     = FRAME_START && (WIDTH != 16'd0) && (HEIGHT != 16'd0);
  assign w_last_x    = (r_ox == r_w - 16'd1);
  assign w_push      = PIX_VALID && w_pix_ready;
  assign w_pop       = !w_empty && M_AXIS.TREADY;
  assign w_last_beat = w_pop && w_last_x && (r_oy == r_h - 16'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_pix_ready = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_pix_ready = !w_full && !w_in_done;
        if (w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_in_cnt <= '0;
      r_total  <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_pixelx <= '0;
      r_pixely <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_start) begin
        r_w      <= WIDTH;
        r_h      <= HEIGHT;
        r_total  <= 32'(WIDTH) * 32'(HEIGHT);
        r_in_cnt <= '0;
        r_ox     <= '0;
        r_oy     <= '0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_in_cnt <= r_in_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pixelx <= r_ox;
        r_pixely <= r_oy;
        if (w_last_x) begin
          r_ox <= '0;
          r_oy <= r_oy + 16'd1;
        end else begin
          r_ox <= r_ox + 16'd1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= PIX_DATA;
  end

  assign PIX_READY     = w_pix_ready;
  assign M_AXIS.TVALID = !w_empty;
  assign M_AXIS.TDATA  = w_empty ? 24'd0 : r_mem[r_rd_ptr];
  assign M_AXIS.TUSER  = !w_empty && (r_ox == 16'd0) && (r_oy == 16'd0);
  assign M_AXIS.TLAST  = !w_empty && w_last_x;
  assign LOGIC_IDLE    = (r_state == S_IDLE);
  assign PIXELX        = r_pixelx;
  assign PIXELY        = r_pixely;
  assign DBG_STATE     = r_state;

`ifdef AQ_DJPEG_PIXOUT_OVF_EN
  logic r_ovf;
  always_ff @(posedge ACLK) begin
    if (RST) r_ovf <= 1'b0;
    else if (PIX_VALID && (w_in_done || r_state == S_IDLE)) r_ovf <= 1'b1;
  end
  assign OVF_ERR = r_ovf;
`endif

endmodule

// File: tb/tb_aq_axis_djpeg_pixout.sv
// Directed bench for aq_axis_djpeg_pixout: frame streaming, backpressure, degenerate sizes, abort.
module tb_aq_axis_djpeg_pixout;

  logic        ACLK = 1'b0;
  logic        RST;
  logic        FRAME_START;
  logic [15:0] WIDTH, HEIGHT;
  logic        PIX_VALID;
  logic [23:0] PIX_DATA;
  logic        PIX_READY;
  logic        LOGIC_IDLE;
  logic [15:0] PIXELX, PIXELY;
  logic        DBG_STATE;
`ifdef AQ_DJPEG_PIXOUT_OVF_EN
  logic        OVF_ERR;
`endif

  aq_axis_djpeg_pixout_if m_axis();

  aq_axis_djpeg_pixout #(.FIFO_AW(4)) dut (
    .ACLK(ACLK), .RST(RST), .FRAME_START(FRAME_START), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY), .M_AXIS(m_axis),
    .LOGIC_IDLE(LOGIC_IDLE), .PIXELX(PIXELX), .PIXELY(PIXELY), .DBG_STATE(DBG_STATE)
`ifdef AQ_DJPEG_PIXOUT_OVF_EN
    , .OVF_ERR(OVF_ERR)
`endif
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard: beats packed as {tuser, tlast, tdata}
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always @(negedge ACLK) begin
    if (!RST && m_axis.TVALID && m_axis.TREADY)
      got_q.push_back({m_axis.TUSER, m_axis.TLAST, m_axis.TDATA});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic frame_start(input logic [15:0] w, input logic [15:0] h);
    WIDTH = w;
    HEIGHT = h;
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] d);
    int budget;
    budget = 200;
    PIX_VALID = 1'b1;
    PIX_DATA = d;
    while (!PIX_READY && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("send_timeout", 32'd0, 32'd1);
    tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 500;
    while (!LOGIC_IDLE && budget > 0) begin
      tick();
      budget--;
    end
    check("idle_reached", 32'(LOGIC_IDLE), 32'd1);
  endtask

  task automatic push_exp(input logic u, input logic l, input logic [23:0] d);
    exp_q.push_back({u, l, d});
  endtask

  task automatic compare_beats(input string tag);
    logic [25:0] g, e;
    check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_beat"}, 32'(g), 32'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b1;
    FRAME_START = 1'b0;
    WIDTH = '0;
    HEIGHT = '0;
    PIX_VALID = 1'b0;
    PIX_DATA = '0;
    m_axis.TREADY = 1'b1;

    // reset
    tick();
    tick();
    RST = 1'b0;
    check("rst_idle", 32'(LOGIC_IDLE), 32'd1);
    check("rst_ready", 32'(PIX_READY), 32'd0);
    check("rst_tvalid", 32'(m_axis.TVALID), 32'd0);
    check("rst_tdata", 32'(m_axis.TDATA), 32'd0);
    check("rst_tuser", 32'(m_axis.TUSER), 32'd0);
    check("rst_tlast", 32'(m_axis.TLAST), 32'd0);
    check("rst_pixelx", 32'(PIXELX), 32'd0);
    check("rst_pixely", 32'(PIXELY), 32'd0);

    // 4x2 frame, back-to-back pixels
    frame_start(16'd4, 16'd2);
    check("f4x2_idle_drop", 32'(LOGIC_IDLE), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_pix(24'(i + 1));
      push_exp(i == 0, (i % 4) == 3, 24'(i + 1));
    end
    check("f4x2_busy_before_last", 32'(LOGIC_IDLE), 32'd0);
    tick();
    check("f4x2_idle_after_last", 32'(LOGIC_IDLE), 32'd1);
    check("f4x2_pixelx", 32'(PIXELX), 32'd3);
    check("f4x2_pixely", 32'(PIXELY), 32'd1);
    compare_beats("f4x2");

    // backpressure: 16x1 with stalled sink
    m_axis.TREADY = 1'b0;
    frame_start(16'd16, 16'd1);
    send_pix(24'h000100);
    check("bp_lat_tvalid", 32'(m_axis.TVALID), 32'd1);
    check("bp_lat_tdata", 32'(m_axis.TDATA), 32'h100);
    for (int i = 1; i < 16; i++) send_pix(24'(32'h100 + i));
    check("bp_full_ready", 32'(PIX_READY), 32'd0);
    check("bp_tuser_head", 32'(m_axis.TUSER), 32'd1);
    repeat (4) tick();
    check("bp_hold_tvalid", 32'(m_axis.TVALID), 32'd1);
    check("bp_hold_tdata", 32'(m_axis.TDATA), 32'h100);
    check("bp_hold_tlast", 32'(m_axis.TLAST), 32'd0);
    for (int i = 0; i < 16; i++) push_exp(i == 0, i == 15, 24'(32'h100 + i));
    m_axis.TREADY = 1'b1;
    wait_idle();
    check("bp_pixelx", 32'(PIXELX), 32'd15);
    check("bp_pixely", 32'(PIXELY), 32'd0);
    compare_beats("bp");

    // degenerate sizes
    frame_start(16'd0, 16'd5);
    check("zero_dim_idle", 32'(LOGIC_IDLE), 32'd1);
    check("zero_dim_ready", 32'(PIX_READY), 32'd0);
    frame_start(16'd1, 16'd1);
    check("one_busy", 32'(LOGIC_IDLE), 32'd0);
    send_pix(24'hABCDEF);
    push_exp(1'b1, 1'b1, 24'hABCDEF);
    tick();
    check("one_idle", 32'(LOGIC_IDLE), 32'd1);
    compare_beats("one");

    // abort mid-frame
    m_axis.TREADY = 1'b0;
    frame_start(16'd8, 16'd8);
    for (int i = 0; i < 14; i++) send_pix(24'(32'h200 + i));
    m_axis.TREADY = 1'b1;
    repeat (10) tick();
    m_axis.TREADY = 1'b0;
    check("abort_pending", 32'(m_axis.TVALID), 32'd1);
    check("abort_pre_pixelx", 32'(PIXELX), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_tvalid", 32'(m_axis.TVALID), 32'd0);
    check("abort_idle", 32'(LOGIC_IDLE), 32'd1);
    check("abort_ready", 32'(PIX_READY), 32'd0);
    for (int i = 0; i < 10; i++) push_exp(i == 0, (i % 8) == 7, 24'(32'h200 + i));
    compare_beats("abort");

    m_axis.TREADY = 1'b1;
    frame_start(16'd2, 16'd2);
    for (int i = 0; i < 4; i++) begin
      send_pix(24'(32'h301 + i));
      push_exp(i == 0, (i % 2) == 1, 24'(32'h301 + i));
    end
    wait_idle();
    check("f2x2_pixelx", 32'(PIXELX), 32'd1);
    check("f2x2_pixely", 32'(PIXELY), 32'd1);
    compare_beats("f2x2");

`ifdef AQ_DJPEG_PIXOUT_OVF_EN
    // stray pixel after the frame is complete
    frame_start(16'd2, 16'd1);
    send_pix(24'h000401);
    send_pix(24'h000402);
    check("ovf_clear", 32'(OVF_ERR), 32'd0);
    PIX_VALID = 1'b1;
    PIX_DATA = 24'h000403;
    tick();
    check("ovf_held_off", 32'(PIX_READY), 32'd0);
    tick();
    PIX_VALID = 1'b0;
    wait_idle();
    check("ovf_set", 32'(OVF_ERR), 32'd1);
    repeat (3) tick();
    check("ovf_sticky", 32'(OVF_ERR), 32'd1);
    push_exp(1'b1, 1'b0, 24'h000401);
    push_exp(1'b0, 1'b1, 24'h000402);
    compare_beats("ovf");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("ovf_rst", 32'(OVF_ERR), 32'd0);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
